uart_host_loader: RTL and testbench
===================================

Name: uart_host_loader

Overview:
- Host-side counterpart of the UART loader protocol.
- Serializes a 32-bit step value to the target as 4 bytes, LSB first.
- Then collects the target's reply and presents it as parallel words with a done pulse: 8-byte return value (optional) followed by an 8-byte cycle count, each LSB first.
- Used in system testbenches and on a companion FPGA that drives the accelerator board.

Parameters:
- SYS_CLK_FREQ, 100, system clock in MHz.
- BAUDRATE, 921600, line rate in bit/s. Bit period is WCNT = SYS_CLK_FREQ*1000000/BAUDRATE cycles (integer division).
- HAS_RETURN_VALUE, 1: 1 = expect 16 reply bytes (return value, then cycle count); 0 = expect 8 (cycle count only).
- TIMEOUT_CYCLES, 100000000, reply inactivity limit in cycles. Used only with the optional feature.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request to begin a transaction.
- STEP  in  32  value to send; sampled on the START cycle.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse when the reply is complete or has timed out.
- RETURN_VALUE  out  64  assembled return value. Held until the next DONE; stays 0 when HAS_RETURN_VALUE=0.
- CYCLE_COUNT  out  64  assembled cycle count. Held until the next DONE.
- FRAME_ERR  out  1  sticky: a reply byte had stop bit = 0. Cleared on accepted START.
- TIMEOUT  out  1  sticky: the reply stalled. Cleared on accepted START.
- TXD  out  1  serial line to the target; idle high.
- RXD  in  1  serial line from the target; idle high.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - TXD=1; BUSY, DONE, FRAME_ERR, TIMEOUT = 0; RETURN_VALUE, CYCLE_COUNT = 0.
  - State IDLE; all counters 0.
  - Reset mid-frame aborts immediately: TXD returns high in the same instant, and no DONE pulse is produced.
- Line format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly WCNT cycles.
  - TX has no inter-byte gap: the next start bit follows the previous stop bit directly.
- State machine:
  - IDLE:
    - START=1 latches STEP into the shift buffer, clears FRAME_ERR/TIMEOUT and the receive accumulator, sets byte index=0, goes to TX.
    - START while not IDLE is ignored.
  - TX:
    - Sends bytes STEP[7:0], [15:8], [23:16], [31:24].
    - After the stop bit of byte 3 ends, goes to RX with byte index=0.
    - The receiver is disarmed during TX; RXD activity there is discarded.
  - RX, start detect: a start bit is recognised when RXD has been low for WCNT/2 consecutive cycles.
  - RX, sampling: each data bit is then sampled every WCNT cycles, and the stop bit is sampled WCNT cycles after bit 7.
  - RX, byte storage: byte k is shifted into a 128-bit accumulator at [8k+7:8k]. A byte with stop=0 sets FRAME_ERR and is still stored.
  - RX exit: after the last expected byte (15, or 7 when HAS_RETURN_VALUE=0), goes to DONE.
  - DONE, output mapping:
    - HAS_RETURN_VALUE=1: RETURN_VALUE<=acc[63:0], CYCLE_COUNT<=acc[127:64].
    - HAS_RETURN_VALUE=0: CYCLE_COUNT<=acc[63:0].
  - DONE, exit: pulses DONE for one cycle, drops BUSY, returns to IDLE.
- Timing:
  - BUSY rises the cycle after START.
  - The TXD start bit begins the cycle after START.
  - DONE asserts 1 cycle after the last stop-bit sample.
  - Outputs update in the same cycle as DONE.
- START on the same cycle as DONE is ignored; START is accepted only when state is IDLE.
- Counters: baud counter is 33 bits; byte index is 5 bits. No wrap is possible within a transaction.

Optional Feature:
- Macro UART_HOST_LOADER_TIMEOUT_EN.
- Defined:
  - In RX, an inactivity counter is cleared on entry to RX and on each completed byte, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: TIMEOUT=1, partial accumulator contents are written to the outputs per the normal mapping, DONE pulses, and the block returns to IDLE.
- Not defined:
  - No counter; TIMEOUT is tied 0.
  - RX waits indefinitely, leaving only reset to exit.

Test Plan:
- SYS_CLK_FREQ=100, BAUDRATE=10000000 (WCNT=10), START with STEP=0x04030201 -> TXD carries frames 0x01,0x02,0x03,0x04, each 100 cycles, back-to-back; BUSY high throughout.
- Target model replies with 16 bytes: 0x64 followed by 7×0x00, then 0x34,0x12 followed by 6×0x00 -> single DONE pulse; RETURN_VALUE=100, CYCLE_COUNT=0x1234; FRAME_ERR=0.
- HAS_RETURN_VALUE=0, reply 0xEF,0xBE,0xAD,0xDE,0,0,0,0 -> DONE after 8 bytes; CYCLE_COUNT=0xDEADBEEF; RETURN_VALUE=0.
- Reply byte 3 with stop bit forced 0 -> FRAME_ERR=1 at DONE, data still assembled; next START clears FRAME_ERR.
- With UART_HOST_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=5000, target sends 5 bytes then stops -> DONE with TIMEOUT=1 roughly 5000 cycles after byte 4; without the macro, no DONE.
- START pulsed again during TX byte 1, then RST_N low during RX byte 2 -> second START ignored; after reset TXD=1, BUSY=0, outputs 0, and no DONE pulse.

Source files
------------

// File: rtl/uart_host_loader.sv
// Host side of the UART loader protocol: sends a 32-bit step, then collects the target's reply.
// Optional reply inactivity timeout is enabled by defining UART_HOST_LOADER_TIMEOUT_EN.
module uart_host_loader #(
  parameter int SYS_CLK_FREQ     = 100,
  parameter int BAUDRATE         = 921600,
  parameter int HAS_RETURN_VALUE = 1,
  parameter int TIMEOUT_CYCLES   = 100000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [31:0] STEP,
  output logic        BUSY,
  output logic        DONE,
  output logic [63:0] RETURN_VALUE,
  output logic [63:0] CYCLE_COUNT,
  output logic        FRAME_ERR,
  output logic        TIMEOUT,
  output logic        TXD,
  input  logic        RXD
);
  localparam longint WCNT = (longint'(SYS_CLK_FREQ) * 1000000) / longint'(BAUDRATE);
  localparam logic [32:0] BIT_LAST  = 33'(WCNT - 1);
  localparam logic [32:0] HALF_LAST = 33'(WCNT / 2 - 1);
  localparam logic [4:0]  BYTE_LAST = (HAS_RETURN_VALUE != 0) ? 5'd15 : 5'd7;

  typedef enum logic [1:0] {S_IDLE, S_TX, S_RX, S_FIN} state_t;

  state_t       state;
  logic [32:0]  baud_cnt;
  logic [3:0]   bit_idx;
  logic [4:0]   byte_idx;
  logic [31:0]  tx_buf;
  logic [7:0]   rx_byte;
  logic [127:0] acc;
  logic         rx_active;
  logic         rx_armed;
  logic         rxd_p0;
  logic         rxd_p1;
  logic         rx_stop_tick;

  assign rx_stop_tick = (state == S_RX) && rx_active && (baud_cnt == BIT_LAST) && (bit_idx == 4'd8);

`ifdef UART_HOST_LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        timeout_hit;
  assign timeout_hit = (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) && !rx_stop_tick;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign TIMEOUT = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= RXD;
      rxd_p1 <= rxd_p0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      tx_buf       <= '0;
      rx_byte      <= '0;
      acc          <= '0;
      rx_active    <= 1'b0;
      rx_armed     <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      RETURN_VALUE <= '0;
      CYCLE_COUNT  <= '0;
      FRAME_ERR    <= 1'b0;
      TXD          <= 1'b1;
`ifdef UART_HOST_LOADER_TIMEOUT_EN
      TIMEOUT      <= 1'b0;
      idle_cnt     <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START && !DONE) begin
            tx_buf    <= STEP;
            acc       <= '0;
            FRAME_ERR <= 1'b0;
`ifdef UART_HOST_LOADER_TIMEOUT_EN
            TIMEOUT   <= 1'b0;
`endif
            byte_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            TXD       <= 1'b0;
            BUSY      <= 1'b1;
            state     <= S_TX;
          end
        end
        // bit_idx 0 = start, 1..8 = data, 9 = stop; tx_buf shifts out LSB first across all bytes
        S_TX: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              if (byte_idx == 5'd3) begin
                byte_idx  <= '0;
                rx_active <= 1'b0;
                rx_armed  <= 1'b0;
`ifdef UART_HOST_LOADER_TIMEOUT_EN
                idle_cnt  <= '0;
`endif
                state     <= S_RX;
              end else begin
                byte_idx <= byte_idx + 5'd1;
                TXD      <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == 4'd8) begin
                TXD <= 1'b1;
              end else begin
                TXD    <= tx_buf[0];
                tx_buf <= {1'b0, tx_buf[31:1]};
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 33'd1;
          end
        end
        S_RX: begin
`ifdef UART_HOST_LOADER_TIMEOUT_EN
          idle_cnt <= rx_stop_tick ? '0 : idle_cnt + 32'd1;
`endif
          // After each byte the line must be seen high again, so a low stop bit cannot retrigger the hunt
          if (!rx_active) begin
            if (rxd_p1) begin
              rx_armed <= 1'b1;
              baud_cnt <= '0;
            end else if (rx_armed) begin
              if (baud_cnt == HALF_LAST) begin
                rx_active <= 1'b1;
                baud_cnt  <= '0;
                bit_idx   <= '0;
              end else begin
                baud_cnt <= baud_cnt + 33'd1;
              end
            end
          end else if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd8) begin
              acc[{byte_idx[3:0], 3'b000} +: 8] <= rx_byte;
              if (!rxd_p1) FRAME_ERR <= 1'b1;
              rx_active <= 1'b0;
              rx_armed  <= 1'b0;
              if (byte_idx == BYTE_LAST) state <= S_FIN;
              else byte_idx <= byte_idx + 5'd1;
            end else begin
              rx_byte <= {rxd_p1, rx_byte[7:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 33'd1;
          end
`ifdef UART_HOST_LOADER_TIMEOUT_EN
          if (timeout_hit) begin
            TIMEOUT <= 1'b1;
            state   <= S_FIN;
          end
`endif
        end
        S_FIN: begin
          if (HAS_RETURN_VALUE != 0) begin
            RETURN_VALUE <= acc[63:0];
            CYCLE_COUNT  <= acc[127:64];
          end else begin
            CYCLE_COUNT <= acc[63:0];
          end
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_host_loader.sv
// Directed bench for uart_host_loader: TX framing, reply assembly, frame error, timeout, reset abort.
module tb_uart_host_loader;
  localparam int WCNT = 10;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start1, start0;
  logic [31:0] step1, step0;
  logic        rxd_line;
  logic        busy1, done1, fe1, to1, txd1;
  logic        busy0, done0, fe0, to0, txd0;
  logic [63:0] rv1, cc1, rv0, cc0;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt1 = 0;
  int done_cnt0 = 0;
  int base1, base0, waited;

  always #5 CLK = ~CLK;

  uart_host_loader #(
    .SYS_CLK_FREQ(100), .BAUDRATE(10000000), .HAS_RETURN_VALUE(1), .TIMEOUT_CYCLES(5000)
  ) dut (
    .CLK(CLK), .RST_N(rst_n), .START(start1), .STEP(step1), .BUSY(busy1), .DONE(done1),
    .RETURN_VALUE(rv1), .CYCLE_COUNT(cc1), .FRAME_ERR(fe1), .TIMEOUT(to1),
    .TXD(txd1), .RXD(rxd_line)
  );

  uart_host_loader #(
    .SYS_CLK_FREQ(100), .BAUDRATE(10000000), .HAS_RETURN_VALUE(0), .TIMEOUT_CYCLES(5000)
  ) dut0 (
    .CLK(CLK), .RST_N(rst_n), .START(start0), .STEP(step0), .BUSY(busy0), .DONE(done0),
    .RETURN_VALUE(rv0), .CYCLE_COUNT(cc0), .FRAME_ERR(fe0), .TIMEOUT(to0),
    .TXD(txd0), .RXD(rxd_line)
  );

  always @(negedge CLK) begin
    if (done1) done_cnt1 <= done_cnt1 + 1;
    if (done0) done_cnt0 <= done_cnt0 + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stop);
    rxd_line = 1'b0;
    wait_neg(WCNT);
    for (int i = 0; i < 8; i++) begin
      rxd_line = v[i];
      wait_neg(WCNT);
    end
    rxd_line = stop;
    wait_neg(WCNT);
    rxd_line = 1'b1;
    wait_neg(WCNT);
  endtask

  // Called on the negedge where start1 was raised; samples every TXD bit at its midpoint.
  task automatic tx_capture(input logic [31:0] exp_step, input bit poke);
    logic [7:0] b;
    int gap;
    b = '0;
    @(negedge CLK);
    start1 = 1'b0;
    check_val("busy_rise", 64'(busy1), 64'd1);
    gap = 5;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 10; j++) begin
        wait_neg(gap);
        gap = WCNT;
        if (j == 0) check_val($sformatf("tx%0d_start", k), 64'(txd1), 64'd0);
        else if (j == 9) check_val($sformatf("tx%0d_stop", k), 64'(txd1), 64'd1);
        else b[j-1] = txd1;
        if (poke && k == 1 && j == 3) begin
          start1 = 1'b1;
          step1  = ~exp_step;
          @(negedge CLK);
          start1 = 1'b0;
          gap = WCNT - 1;
        end
      end
      check_val($sformatf("tx%0d_byte", k), 64'(b), 64'(exp_step[k*8 +: 8]));
      check_val($sformatf("tx%0d_busy", k), 64'(busy1), 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0; step1 = '0; step0 = '0; rxd_line = 1'b1;
    wait_neg(3);
    check_val("rst_txd", 64'(txd1), 64'd1);
    check_val("rst_busy", 64'(busy1), 64'd0);
    check_val("rst_done", 64'(done1), 64'd0);
    check_val("rst_rv", rv1, 64'd0);
    check_val("rst_cc", cc1, 64'd0);
    check_val("rst_fe", 64'(fe1), 64'd0);
    check_val("rst_to", 64'(to1), 64'd0);
    check_val("rst_txd0", 64'(txd0), 64'd1);
    rst_n = 1'b1;
    wait_neg(3);

    // Basic transaction with return value
    step1 = 32'h04030201; start1 = 1'b1;
    tx_capture(32'h04030201, 1'b0);
    base1 = done_cnt1;
    wait_neg(10);
    send_byte(8'h64, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(8'h00, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(8'h00, 1'b1);
    wait_neg(5);
    check_val("t1_done_cnt", 64'(done_cnt1 - base1), 64'd1);
    check_val("t1_rv", rv1, 64'd100);
    check_val("t1_cc", cc1, 64'h1234);
    check_val("t1_fe", 64'(fe1), 64'd0);
    check_val("t1_busy", 64'(busy1), 64'd0);

    // Cycle count only
    step0 = 32'hCAFEF00D; start0 = 1'b1;
    wait_neg(1);
    start0 = 1'b0;
    check_val("t2_busy", 64'(busy0), 64'd1);
    wait_neg(410);
    base0 = done_cnt0; base1 = done_cnt1;
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
    wait_neg(5);
    check_val("t2_done_cnt", 64'(done_cnt0 - base0), 64'd1);
    check_val("t2_cc", cc0, 64'hDEADBEEF);
    check_val("t2_rv", rv0, 64'd0);
    check_val("t2_busy_end", 64'(busy0), 64'd0);
    check_val("t2_idle_ignores_rx", 64'(done_cnt1 - base1), 64'd0);

    // Frame error on reply byte 3
    step1 = 32'h0; start1 = 1'b1;
    wait_neg(1);
    start1 = 1'b0;
    wait_neg(410);
    base1 = done_cnt1;
    for (int k = 0; k < 16; k++) send_byte(8'(k + 1), (k != 3));
    wait_neg(5);
    check_val("t3_done_cnt", 64'(done_cnt1 - base1), 64'd1);
    check_val("t3_fe", 64'(fe1), 64'd1);
    check_val("t3_rv", rv1, 64'h0807060504030201);
    check_val("t3_cc", cc1, 64'h100F0E0D0C0B0A09);

    // Next START clears FRAME_ERR; reply stalls after 5 bytes
    step1 = 32'h0; start1 = 1'b1;
    wait_neg(1);
    start1 = 1'b0;
    check_val("t4_fe_clear", 64'(fe1), 64'd0);
    wait_neg(409);
    base1 = done_cnt1;
    for (int k = 0; k < 5; k++) send_byte(8'(8'hA1 + k), 1'b1);
`ifdef UART_HOST_LOADER_TIMEOUT_EN
    waited = 0;
    while (done_cnt1 == base1 && waited < 6000) begin
      wait_neg(1);
      waited++;
    end
    wait_neg(3);
    check_val("t4_done_cnt", 64'(done_cnt1 - base1), 64'd1);
    check_val("t4_latency_ok", 64'(waited > 4900 && waited < 5050), 64'd1);
    check_val("t4_timeout", 64'(to1), 64'd1);
    check_val("t4_rv_partial", rv1, 64'h000000A5A4A3A2A1);
    check_val("t4_cc_partial", cc1, 64'd0);
    check_val("t4_busy", 64'(busy1), 64'd0);
`else
    wait_neg(6000);
    check_val("t4_no_done", 64'(done_cnt1 - base1), 64'd0);
    check_val("t4_still_busy", 64'(busy1), 64'd1);
    check_val("t4_timeout_tied", 64'(to1), 64'd0);
`endif
    rst_n = 1'b0;
    wait_neg(2);
    check_val("t4_rst_busy", 64'(busy1), 64'd0);
    check_val("t4_rst_to", 64'(to1), 64'd0);
    rst_n = 1'b1;
    wait_neg(3);

    // Second START during TX ignored, then reset during RX aborts
    step1 = 32'h44332211; start1 = 1'b1;
    tx_capture(32'h44332211, 1'b1);
    base1 = done_cnt1;
    wait_neg(10);
    send_byte(8'h55, 1'b1);
    rxd_line = 1'b0;
    wait_neg(4 * WCNT);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_rst_txd", 64'(txd1), 64'd1);
    check_val("t5_rst_busy", 64'(busy1), 64'd0);
    check_val("t5_rst_done", 64'(done1), 64'd0);
    check_val("t5_rst_rv", rv1, 64'd0);
    check_val("t5_rst_cc", cc1, 64'd0);
    rxd_line = 1'b1;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(300);
    check_val("t5_no_done", 64'(done_cnt1 - base1), 64'd0);
    check_val("t5_idle_busy", 64'(busy1), 64'd0);

    // Reset inside a TX start bit drives TXD high immediately
    step1 = 32'h0; start1 = 1'b1;
    wait_neg(1);
    start1 = 1'b0;
    wait_neg(3);
    check_val("t6_txd_start", 64'(txd1), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_txd", 64'(txd1), 64'd1);
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
